// File: rtl/load_store_unit.sv
// Load/store sequencer between the execute stage and a byte-wide data memory.
// Splits 8/16-bit little-endian transfers into byte accesses and returns one response per request.
module load_store_unit #(
  parameter int ADDR_W   = 7,
  parameter int MEM_SIZE = 128
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic              req_half,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [15:0]       req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [15:0]       resp_data,
  output logic              resp_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC0 = 2'd1,
    ACC1 = 2'd2,
    RESP = 2'd3
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MEM_SIZE - 1);
  localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);

  state_t            state_q, state_d;
  logic              we_q, we_d;
  logic              half_q, half_d;
  logic              signed_q, signed_d;
  logic              err_q, err_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [15:0]       wdata_q, wdata_d;
  logic [15:0]       data_q, data_d;

  // Next-state and request/data capture logic.
  always_comb begin
    state_d  = state_q;
    we_d     = we_q;
    half_d   = half_q;
    signed_d = signed_q;
    err_d    = err_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    data_d   = data_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          we_d     = req_we;
          half_d   = req_half;
          signed_d = req_signed;
          addr_d   = req_addr;
          wdata_d  = req_wdata;
          data_d   = 16'h0000;
          // A halfword at the last byte would run off the end of memory.
          if (req_half && (req_addr == LAST_ADDR)) begin
            err_d   = 1'b1;
            state_d = RESP;
          end else begin
            err_d   = 1'b0;
            state_d = ACC0;
          end
        end else begin
          state_d = IDLE;
        end
      end
      ACC0: begin
        if (!we_q) begin
          data_d[7:0] = mem_rdata;
        end else begin
          data_d = data_q;
        end
        state_d = half_q ? ACC1 : RESP;
      end
      ACC1: begin
        if (!we_q) begin
          data_d[15:8] = mem_rdata;
        end else begin
          data_d = data_q;
        end
        state_d = RESP;
      end
      RESP: begin
        if (resp_ready) begin
          state_d = IDLE;
        end else begin
          state_d = RESP;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and request registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      we_q     <= 1'b0;
      half_q   <= 1'b0;
      signed_q <= 1'b0;
      err_q    <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= 16'h0000;
      data_q   <= 16'h0000;
    end else begin
      state_q  <= state_d;
      we_q     <= we_d;
      half_q   <= half_d;
      signed_q <= signed_d;
      err_q    <= err_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      data_q   <= data_d;
    end
  end

  // Memory strobes and response fields decoded from the registered state.
  always_comb begin
    mem_addr   = '0;
    mem_rd     = 1'b0;
    mem_wr     = 1'b0;
    mem_wdata  = 8'h00;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    resp_data  = 16'h0000;
    resp_err   = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
      end
      ACC0: begin
        mem_addr  = addr_q;
        mem_rd    = ~we_q;
        mem_wr    = we_q;
        mem_wdata = we_q ? wdata_q[7:0] : 8'h00;
      end
      ACC1: begin
        mem_addr  = addr_q + ADDR_ONE;
        mem_rd    = ~we_q;
        mem_wr    = we_q;
        mem_wdata = we_q ? wdata_q[15:8] : 8'h00;
      end
      RESP: begin
        resp_valid = 1'b1;
        resp_err   = err_q;
        if (we_q || err_q) begin
          resp_data = 16'h0000;
        end else if (half_q) begin
          resp_data = data_q;
        end else begin
          resp_data = {{8{signed_q & data_q[7]}}, data_q[7:0]};
        end
      end
      default: begin
        req_ready = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed vector table, corner sequences,
// and random traffic checked against an array-based memory reference model.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_we, req_half, req_signed;
  logic [6:0]  req_addr;
  logic [15:0] req_wdata;
  logic        resp_valid, resp_ready, resp_err;
  logic [15:0] resp_data;
  logic [6:0]  mem_addr;
  logic        mem_rd, mem_wr;
  logic [7:0]  mem_wdata, mem_rdata;

  logic [7:0]  mem     [0:127];
  logic [7:0]  ref_mem [0:127];
  int          n_checks = 0;
  int          n_errs   = 0;
  int          mem_act  = 0;

  load_store_unit #(.ADDR_W(7), .MEM_SIZE(128)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_half(req_half),
    .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data), .resp_err(resp_err),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr];

  always @(posedge clk) begin
    if (mem_wr) mem[mem_addr] <= mem_wdata;
  end

  always @(negedge clk) begin
    if (mem_rd || mem_wr) mem_act = mem_act + 1;
  end

  typedef struct {
    logic        we;
    logic        half;
    logic        sgn;
    logic [6:0]  addr;
    logic [15:0] wdata;
    logic [15:0] exp_data;
    logic        exp_err;
    int          exp_lat;
    int          hold;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks = n_checks + 1;
    if (act !== exp) begin
      n_errs = n_errs + 1;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: result of an access computed from the byte array and the access rules.
  task automatic model(input logic we, input logic half, input logic sgn, input logic [6:0] a,
                       output logic [15:0] d, output logic e, output int lat);
    int ai;
    ai = int'(a);
    e = half && (ai + 1 > 127);
    if (e) begin
      d = 16'h0000; lat = 1;
    end else begin
      lat = half ? 3 : 2;
      if (we) d = 16'h0000;
      else if (half) d = {ref_mem[ai + 1], ref_mem[ai]};
      else d = sgn ? {{8{ref_mem[ai][7]}}, ref_mem[ai]} : {8'h00, ref_mem[ai]};
    end
  endtask

  task automatic run_txn(input vec_t v);
    int lat;
    int act0;
    int waitc;
    logic [15:0] held;
    waitc = 0;
    while (!req_ready && waitc < 10) begin
      @(posedge clk); #1; waitc++;
    end
    chk("req_ready_before", req_ready, 1'b1);
    req_valid = 1'b1; req_we = v.we; req_half = v.half; req_signed = v.sgn;
    req_addr = v.addr; req_wdata = v.wdata;
    act0 = mem_act;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 1;
    while (!resp_valid && lat < 10) begin
      @(posedge clk); #1; lat++;
    end
    chk("resp_valid", resp_valid, 1'b1);
    chk("latency", lat, v.exp_lat);
    chk("resp_data", resp_data, v.exp_data);
    chk("resp_err", resp_err, v.exp_err);
    chk("mem_accesses", mem_act - act0, v.exp_err ? 0 : (v.half ? 2 : 1));
    held = resp_data;
    for (int i = 0; i < v.hold; i++) begin
      req_valid = 1'b1; req_addr = 7'h05; req_we = 1'b0; req_half = 1'b0;
      @(posedge clk); #1;
      chk("hold_valid", resp_valid, 1'b1);
      chk("hold_data", resp_data, held);
      chk("hold_req_ready", req_ready, 1'b0);
    end
    req_valid = 1'b0;
    act0 = mem_act;
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    chk("resp_valid_drop", resp_valid, 1'b0);
    chk("req_ready_after", req_ready, 1'b1);
    if (v.hold > 0) begin
      @(posedge clk); #1;
      chk("no_stray_accept", mem_act - act0, 0);
      chk("no_stray_resp", resp_valid, 1'b0);
    end
    if (v.we && !v.exp_err) begin
      ref_mem[v.addr] = v.wdata[7:0];
      if (v.half) ref_mem[v.addr + 7'd1] = v.wdata[15:8];
    end
  endtask

  vec_t tbl[$];
  vec_t v;
  logic [7:0] old41;
  int mism;

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_half = 1'b0; req_signed = 1'b0;
    req_addr = 7'h00; req_wdata = 16'h0000; resp_ready = 1'b0;
    for (int i = 0; i < 128; i++) begin
      mem[i] = 8'($urandom);
      ref_mem[i] = mem[i];
    end
    #12;
    chk("rst_req_ready", req_ready, 1'b1);
    chk("rst_resp_valid", resp_valid, 1'b0);
    chk("rst_resp_data", resp_data, 16'h0000);
    chk("rst_resp_err", resp_err, 1'b0);
    chk("rst_mem_strobes", {mem_rd, mem_wr}, 2'b00);
    chk("rst_mem_addr_wdata", {mem_addr, mem_wdata}, 15'h0000);
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;

    //        we    half  sgn   addr   wdata     exp_data  err   lat hold
    tbl.push_back('{1'b1, 1'b0, 1'b0, 7'h10, 16'h00A5, 16'h0000, 1'b0, 2, 0});
    tbl.push_back('{1'b0, 1'b0, 1'b0, 7'h10, 16'h0000, 16'h00A5, 1'b0, 2, 0});
    tbl.push_back('{1'b1, 1'b1, 1'b0, 7'h20, 16'h1234, 16'h0000, 1'b0, 3, 0});
    tbl.push_back('{1'b0, 1'b0, 1'b0, 7'h20, 16'h0000, 16'h0034, 1'b0, 2, 0});
    tbl.push_back('{1'b0, 1'b0, 1'b1, 7'h21, 16'h0000, 16'h0012, 1'b0, 2, 0});
    tbl.push_back('{1'b0, 1'b1, 1'b0, 7'h20, 16'h0000, 16'h1234, 1'b0, 3, 0});
    tbl.push_back('{1'b1, 1'b0, 1'b0, 7'h30, 16'h0080, 16'h0000, 1'b0, 2, 0});
    tbl.push_back('{1'b0, 1'b0, 1'b1, 7'h30, 16'h0000, 16'hFF80, 1'b0, 2, 0});
    tbl.push_back('{1'b0, 1'b0, 1'b0, 7'h30, 16'h0000, 16'h0080, 1'b0, 2, 0});
    tbl.push_back('{1'b0, 1'b1, 1'b0, 7'h7F, 16'h0000, 16'h0000, 1'b1, 1, 0});
    tbl.push_back('{1'b1, 1'b1, 1'b0, 7'h7F, 16'hDEAD, 16'h0000, 1'b1, 1, 0});
    tbl.push_back('{1'b1, 1'b0, 1'b0, 7'h7F, 16'h775A, 16'h0000, 1'b0, 2, 0});
    tbl.push_back('{1'b0, 1'b0, 1'b0, 7'h7F, 16'h0000, 16'h005A, 1'b0, 2, 0});
    tbl.push_back('{1'b1, 1'b1, 1'b0, 7'h7E, 16'hC3F0, 16'h0000, 1'b0, 3, 0});
    tbl.push_back('{1'b0, 1'b1, 1'b1, 7'h7E, 16'h0000, 16'hC3F0, 1'b0, 3, 0});
    tbl.push_back('{1'b1, 1'b1, 1'b0, 7'h60, 16'h2222, 16'h0000, 1'b0, 3, 0});
    tbl.push_back('{1'b1, 1'b0, 1'b0, 7'h60, 16'hFF11, 16'h0000, 1'b0, 2, 0});
    tbl.push_back('{1'b0, 1'b1, 1'b0, 7'h60, 16'h0000, 16'h2211, 1'b0, 3, 0});
    tbl.push_back('{1'b0, 1'b1, 1'b0, 7'h20, 16'h0000, 16'h1234, 1'b0, 3, 5});
    foreach (tbl[i]) run_txn(tbl[i]);

    // Reset in the middle of a halfword store: low byte lands, high byte does not.
    old41 = mem[7'h41];
    req_valid = 1'b1; req_we = 1'b1; req_half = 1'b1; req_signed = 1'b0;
    req_addr = 7'h40; req_wdata = 16'hBEEF;
    @(posedge clk); #1; req_valid = 1'b0;
    @(posedge clk); #1;
    chk("acc1_wr_active", mem_wr, 1'b1);
    reset = 1'b1; #1;
    chk("rst_mid_mem_wr", mem_wr, 1'b0);
    chk("rst_mid_req_ready", req_ready, 1'b1);
    chk("rst_mid_resp_valid", resp_valid, 1'b0);
    @(posedge clk); #1;
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;
    chk("rst_mid_low_byte", mem[7'h40], 8'hEF);
    chk("rst_mid_high_byte", mem[7'h41], old41);
    chk("rst_mid_no_resp", resp_valid, 1'b0);
    chk("rst_mid_idle", req_ready, 1'b1);
    ref_mem[7'h40] = 8'hEF;

    // Random traffic against the reference model.
    for (int n = 0; n < 80; n++) begin
      v.we    = 1'($urandom);
      v.half  = 1'($urandom);
      v.sgn   = 1'($urandom);
      v.addr  = ($urandom_range(0, 3) == 0) ? 7'(126 + $urandom_range(0, 1)) : 7'($urandom);
      v.wdata = 16'($urandom);
      v.hold  = $urandom_range(0, 2);
      model(v.we, v.half, v.sgn, v.addr, v.exp_data, v.exp_err, v.exp_lat);
      run_txn(v);
    end

    mism = 0;
    for (int i = 0; i < 128; i++) if (mem[i] !== ref_mem[i]) mism++;
    chk("final_memory_image", mism, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
